// File: rtl/mips_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pc_pkg
// Description : Shared fetch-stage definitions. Holds the boot address and
//               exception vector (also used by CP0 and the fetch exception
//               checker), the PC sequencer state type and the next-PC source
//               encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pc_pkg;

    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VECTOR = 32'h0000_4180;

    // Sequencer state: BOOT is the single bubble cycle after reset, EXC/RET
    // mark the first fetch at the handler / at EPC.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2,
        RET  = 2'd3
    } pc_state_t;

    // Which rule picked the next PC; the top uses it to steer BDF and the
    // ERET squash without re-deriving the priority.
    typedef enum logic [2:0] {
        SEL_EXC    = 3'd0,
        SEL_BOOT   = 3'd1,
        SEL_ERET   = 3'd2,
        SEL_HOLD   = 3'd3,
        SEL_BRANCH = 3'd4,
        SEL_SEQ    = 3'd5
    } pc_sel_t;

endpackage : mips_pc_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Purely combinational next-PC / next-state priority mux for
//               the fetch stage. Reset is handled by the register in the top.
// Ports       : state      - current sequencer state
//               pc, pc4    - current fetch address and its successor
//               stall      - fetch-stage hold
//               branch,npc - taken redirect from decode and its target
//               int_req    - CP0 exception/interrupt request
//               eret, epc  - ERET in decode and the return address
//               next_pc    - PC to load on the next edge
//               next_state - state to load on the next edge
//               sel        - which priority rule produced next_pc
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET_ADDR,
    parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR
) (
    input  pc_state_t   state,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] npc,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output pc_state_t   next_state,
    output pc_sel_t     sel
);

    always_comb begin
        next_pc    = pc4;
        next_state = RUN;
        sel        = SEL_SEQ;
        if (int_req) begin
            // Exception entry ignores the stall and discards a concurrent ERET.
            next_pc    = EXC_VECTOR;
            next_state = EXC;
            sel        = SEL_EXC;
        end else if (state == BOOT) begin
            // The boot bubble cannot be held; the boot address is then
            // fetched again, this time as a real instruction.
            next_pc    = RESET_PC;
            next_state = RUN;
            sel        = SEL_BOOT;
        end else if (eret && !stall) begin
            next_pc    = epc;
            next_state = RET;
            sel        = SEL_ERET;
        end else if (stall) begin
            next_pc    = pc;
            next_state = state;
            sel        = SEL_HOLD;
        end else if (branch) begin
            // Targets are passed through unaligned; the fetch checker flags AdEL.
            next_pc    = npc;
            next_state = RUN;
            sel        = SEL_BRANCH;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter register and next-PC sequencer for the fetch
//               stage of the five-stage MIPS pipeline. Arbitrates sequential
//               fetch, stall, branch/jump redirect, exception entry and ERET.
//               Build option PC_DELAY_SLOT_BD_EN: when defined, BDF tracks
//               JumpInD; when undefined BDF is tied low and no BD register
//               exists.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               StallF          - hazard-unit hold of fetch
//               BranchD, NPCD   - taken redirect from decode and its target
//               JumpInD         - decode holds a branch/jump (taken or not)
//               IntReq          - CP0 exception/interrupt request pulse
//               EretD, EPC      - ERET in decode and the return address
//               PCF, PC4F       - fetch address and fetch address + 4
//               BDF             - fetched instruction is in a delay slot
//               ValidF          - fetched instruction is to be issued
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET_ADDR,
    parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        BranchD,
    input  logic [31:0] NPCD,
    input  logic        JumpInD,
    input  logic        IntReq,
    input  logic        EretD,
    input  logic [31:0] EPC,
    output logic [31:0] PCF,
    output logic [31:0] PC4F,
    output logic        BDF,
    output logic        ValidF
);

    pc_state_t   r_state;
    logic [31:0] r_pc;
    pc_state_t   w_next_state;
    logic [31:0] w_next_pc;
    pc_sel_t     w_sel;
    logic        w_bd;

    // ---------------------------------------------------------------- next state
    pc_next_sel #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .state      (r_state),
        .pc         (r_pc),
        .pc4        (PC4F),
        .stall      (StallF),
        .branch     (BranchD),
        .npc        (NPCD),
        .int_req    (IntReq),
        .eret       (EretD),
        .epc        (EPC),
        .next_pc    (w_next_pc),
        .next_state (w_next_state),
        .sel        (w_sel)
    );

    // ------------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // ------------------------------------------------------- delay-slot flag
`ifdef PC_DELAY_SLOT_BD_EN
    logic r_bd;

    // Loaded from JumpInD only on a normal advance; held on stall and cleared
    // on boot, exception entry and ERET return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bd <= 1'b0;
        end else begin
            case (w_sel)
                SEL_HOLD:            r_bd <= r_bd;
                SEL_BRANCH, SEL_SEQ: r_bd <= JumpInD;
                default:             r_bd <= 1'b0;
            endcase
        end
    end

    assign w_bd = r_bd;
`else
    logic w_unused_jump_in;

    assign w_unused_jump_in = JumpInD;
    assign w_bd             = 1'b0;
`endif

    // ------------------------------------------------------------------ outputs
    // ValidF drops in BOOT, and also in the cycle an ERET is accepted: ERET has
    // no delay slot, so the instruction fetched alongside it must enter F/D as
    // a bubble on that same edge.
    always_comb begin
        PCF    = r_pc;
        PC4F   = r_pc + 32'd4;
        BDF    = w_bd;
        ValidF = (r_state != BOOT) && (w_sel != SEL_ERET);
    end

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit. Directed scenarios
//               followed by randomized stimulus, all checked against a
//               behavioural model of the fetch-PC rules.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_EXC_VEC  = 32'h0000_4180;
`ifdef PC_DELAY_SLOT_BD_EN
    localparam bit C_BD_EN = 1'b1;
`else
    localparam bit C_BD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        BranchD;
    logic [31:0] NPCD;
    logic        JumpInD;
    logic        IntReq;
    logic        EretD;
    logic [31:0] EPC;
    logic [31:0] PCF;
    logic [31:0] PC4F;
    logic        BDF;
    logic        ValidF;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch address, "bubble after reset" flag, BD flag.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_bd;

    pc_fetch_unit dut (
        .clk     (clk),
        .reset   (reset),
        .StallF  (StallF),
        .BranchD (BranchD),
        .NPCD    (NPCD),
        .JumpInD (JumpInD),
        .IntReq  (IntReq),
        .EretD   (EretD),
        .EPC     (EPC),
        .PCF     (PCF),
        .PC4F    (PC4F),
        .BDF     (BDF),
        .ValidF  (ValidF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model at the
    // falling edge, then advance the model on the rising edge.
    task automatic step(input bit rs, input bit st, input bit br, input logic [31:0] np,
                        input bit jn, input bit ir, input bit er, input logic [31:0] ep);
        bit exp_valid;
        reset = rs; StallF = st; BranchD = br; NPCD = np;
        JumpInD = jn; IntReq = ir; EretD = er; EPC = ep;
        #4;
        exp_valid = !m_boot && !(er && !st && !ir);
        check("pcf",    PCF,              m_pc);
        check("pc4f",   PC4F,             m_pc + 32'd4);
        check("bdf",    {31'b0, BDF},     {31'b0, m_bd});
        check("validf", {31'b0, ValidF},  {31'b0, exp_valid});
        @(posedge clk);
        if (rs) begin
            m_pc = C_RESET_PC; m_boot = 1'b1; m_bd = 1'b0;
        end else if (ir) begin
            m_pc = C_EXC_VEC;  m_boot = 1'b0; m_bd = 1'b0;
        end else if (m_boot) begin
            m_pc = C_RESET_PC; m_boot = 1'b0; m_bd = 1'b0;
        end else if (er && !st) begin
            m_pc = ep;         m_bd = 1'b0;
        end else if (!st) begin
            m_bd = C_BD_EN && jn;
            m_pc = br ? np : m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic step_idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic quiet();
        reset = 1'b0; StallF = 1'b0; BranchD = 1'b0; NPCD = 32'h0;
        JumpInD = 1'b0; IntReq = 1'b0; EretD = 1'b0; EPC = 32'h0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_pc = C_RESET_PC; m_boot = 1'b1; m_bd = 1'b0;
        check("rst_pcf",    PCF,             32'h0000_3000);
        check("rst_pc4f",   PC4F,            32'h0000_3004);
        check("rst_bdf",    {31'b0, BDF},    32'h0);
        check("rst_validf", {31'b0, ValidF}, 32'h0);

        // Boot bubble then sequential fetch.
        step_idle();
        quiet();
        check("boot_pc",    PCF,             32'h0000_3000);
        check("boot_valid", {31'b0, ValidF}, 32'h1);
        step_idle(); check("seq_3004", PCF, 32'h0000_3004);
        step_idle(); check("seq_3008", PCF, 32'h0000_3008);

        // Stall at 0x3010 with BDF set beforehand.
        step_idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_stall", PCF, 32'h0000_3010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_pc", PCF,          32'h0000_3010);
        check("stall_bd", {31'b0, BDF}, {31'b0, C_BD_EN});
        step_idle(); check("post_stall", PCF, 32'h0000_3014);

        // Taken branch at 0x3020.
        repeat (3) step_idle();
        check("at_3020", PCF, 32'h0000_3020);
        step(1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b0, 1'b0, 32'h0);
        check("br_pc", PCF,          32'h0000_3100);
        check("br_bd", {31'b0, BDF}, {31'b0, C_BD_EN});

        // IntReq beats StallF and EretD.
        step(1'b0, 1'b0, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
        quiet();
        check("exc_pc",    PCF,             32'h0000_4180);
        check("exc_bd",    {31'b0, BDF},    32'h0);
        check("exc_valid", {31'b0, ValidF}, 32'h1);

        // ERET squashes its companion fetch and returns to EPC.
        repeat (8) step_idle();
        check("at_41a0", PCF, 32'h0000_41A0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3044);
        quiet();
        check("ret_pc",    PCF,             32'h0000_3044);
        check("ret_valid", {31'b0, ValidF}, 32'h1);

        // Misaligned target passes unchanged.
        step(1'b0, 1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 32'h0);
        check("misalign", PCF, 32'h0000_3002);
        step_idle(); check("misalign_seq", PCF, 32'h0000_3006);

        // Wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        step_idle(); check("wrap", PCF, 32'h0000_0000);

        // Randomized traffic, including mid-run resets.
        for (int i = 0; i < 600; i++) begin
            bit          rs, st, br, jn, ir, er;
            logic [31:0] np, ep;
            rs = ($urandom_range(99) == 0);
            st = ($urandom_range(3) == 0);
            br = ($urandom_range(4) == 0);
            np = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            jn = ($urandom_range(1) == 1);
            ir = ($urandom_range(24) == 0);
            er = ($urandom_range(14) == 0);
            ep = $urandom;
            step(rs, st, br, np, jn, ir, er, ep);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
